// File: rtl/bht_update_gen.sv
// ============================================================================
// bht_update_gen : pairs in-order branch outcomes with outstanding predictions
//                  and emits registered BHT updates plus mispredict pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv;
  localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic                   taken;
  } bht_update_t;
endpackage

module bht_update_gen #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          debug_mode_i,
  input  logic                          pred_valid_i,
  input  logic [riscv::VLEN-1:0]        pred_pc_i,
  input  logic                          pred_taken_i,
  output logic                          pred_ready_o,
  input  logic                          res_valid_i,
  input  logic                          res_taken_i,
  output ariane_pkg::bht_update_t       bht_update_o,
  output logic                          mispredict_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          underflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [riscv::VLEN-1:0]  pc_mem_q [DEPTH];
  logic [DEPTH-1:0]        taken_mem_q;

  logic [PTR_W-1:0]        rptr_q, rptr_d;
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  ariane_pkg::bht_update_t bht_update_q, bht_update_d;
  logic                    mispredict_q, mispredict_d;
  logic                    underflow_q, underflow_d;

  logic                    push;
  logic                    pop;
  logic                    head_taken;
  logic [riscv::VLEN-1:0]  head_pc;

  assign pred_ready_o = (count_q != FULL_CNT);
  assign count_o      = count_q;
  assign bht_update_o = bht_update_q;
  assign mispredict_o = mispredict_q;
  assign underflow_o  = underflow_q;

  // Flush cancels both same-cycle push and resolve.
  assign push       = pred_valid_i && pred_ready_o && !flush_i;
  assign pop        = res_valid_i && (count_q != '0) && !flush_i;
  assign head_pc    = pc_mem_q[rptr_q];
  assign head_taken = taken_mem_q[rptr_q];

  always_comb begin
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    count_d      = count_q;
    underflow_d  = underflow_q;
    bht_update_d = bht_update_q;
    mispredict_d = 1'b0;
    bht_update_d.valid = 1'b0;

    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d             = rptr_q + PTR_W'(1);
        bht_update_d.valid = !debug_mode_i;
        bht_update_d.pc    = head_pc;
        bht_update_d.taken = res_taken_i;
        mispredict_d       = (head_taken != res_taken_i) && !debug_mode_i;
      end
      if (res_valid_i && (count_q == '0)) begin
        underflow_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      bht_update_q <= '0;
      mispredict_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      bht_update_q <= bht_update_d;
      mispredict_q <= mispredict_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage needs no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      pc_mem_q[wptr_q]    <= pred_pc_i;
      taken_mem_q[wptr_q] <= pred_taken_i;
    end
  end

endmodule

`default_nettype wire
